// File: rtl/collision_scanner.sv
// collision_scanner: scans a table of N_OBJ objects against one query point,
// one slot per cycle, using a square (Chebyshev) or diamond (Manhattan) footprint.
module collision_scanner #(
  parameter int N_OBJ      = 8,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int IW         = $clog2(N_OBJ)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [XW-1:0] wr_radius,
  input  logic          wr_valid,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] check_x,
  input  logic [YW-1:0] check_y,
  input  logic          shape,
  output logic          resp_valid,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [IW:0]   hit_count
);

  localparam int SW = ((XW > YW) ? XW : YW) + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]    objX_q [N_OBJ];
  logic [YW-1:0]    objY_q [N_OBJ];
  logic [XW-1:0]    objR_q [N_OBJ];
  logic [N_OBJ-1:0] objV_q;

  logic [IW-1:0] idx_q, idx_d;
  logic [XW-1:0] qx_q, qx_d;
  logic [YW-1:0] qy_q, qy_d;
  logic          shape_q, shape_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] hitIdx_q, hitIdx_d;
  logic [IW:0]   hitCount_q, hitCount_d;

  // Valid bits are the only table state that reset must clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      objV_q <= '0;
    end else if (wr_en && (int'(wr_idx) < N_OBJ)) begin
      objV_q[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && wr_en && (int'(wr_idx) < N_OBJ)) begin
      objX_q[wr_idx] <= wr_x;
      objY_q[wr_idx] <= wr_y;
      objR_q[wr_idx] <= wr_radius;
    end
  end

  logic [XW-1:0] curX;
  logic [YW-1:0] curY;
  logic [XW-1:0] curR;
  logic          curV;
  logic [XW:0]   ax, bx, dx;
  logic [YW:0]   ay, by, dy;
  logic [SW-1:0] rExt, dxExt, dyExt, sumD;
  logic          collide;

  // Operands are zero-extended before subtraction so the distance never wraps.
  always_comb begin
    curX  = objX_q[idx_q];
    curY  = objY_q[idx_q];
    curR  = objR_q[idx_q];
    curV  = objV_q[idx_q];
    ax    = {1'b0, qx_q};
    bx    = {1'b0, curX};
    ay    = {1'b0, qy_q};
    by    = {1'b0, curY};
    dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy    = (ay >= by) ? (ay - by) : (by - ay);
    rExt  = SW'(curR);
    dxExt = SW'(dx);
    dyExt = SW'(dy);
    sumD  = dxExt + dyExt;
    if (shape_q) begin
      collide = curV && (rExt > sumD);
    end else begin
      collide = curV && (rExt > dxExt) && (rExt > dyExt);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    shape_d    = shape_q;
    hit_d      = hit_q;
    hitIdx_d   = hitIdx_q;
    hitCount_d = hitCount_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = SCAN;
          idx_d      = '0;
          qx_d       = check_x;
          qy_d       = check_y;
          shape_d    = shape;
          hit_d      = 1'b0;
          hitIdx_d   = '0;
          hitCount_d = '0;
        end
      end
      SCAN: begin
        if (collide) begin
          if (!hit_q) begin
            hit_d    = 1'b1;
            hitIdx_d = idx_q;
          end
          hitCount_d = hitCount_q + (IW + 1)'(1);
        end
        if ((idx_q == LAST_IDX) || (EARLY_EXIT && collide)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      shape_q    <= 1'b0;
      hit_q      <= 1'b0;
      hitIdx_q   <= '0;
      hitCount_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      shape_q    <= shape_d;
      hit_q      <= hit_d;
      hitIdx_q   <= hitIdx_d;
      hitCount_q <= hitCount_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign hit        = hit_q;
  assign hit_idx    = hitIdx_q;
  assign hit_count  = hitCount_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench: two scanners (full scan and early exit) share stimulus and
// are compared every cycle against a table-level behavioural model.
module tb_collision_scanner;

  localparam int N  = 8;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int IW = 3;
  localparam int XMAX = (1 << XW) - 1;

  logic          Clk;
  logic          Reset;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [XW-1:0] wr_radius;
  logic          wr_valid;
  logic          req_valid;
  logic [XW-1:0] check_x;
  logic [YW-1:0] check_y;
  logic          shape;

  logic          readyO [2];
  logic          respO  [2];
  logic          hitO   [2];
  logic [IW-1:0] idxO   [2];
  logic [IW:0]   cntO   [2];

  // Instance 0 always scans every slot; instance 1 stops at the first hit.
  collision_scanner #(.N_OBJ(N), .XW(XW), .YW(YW), .EARLY_EXIT(1'b0)) uFull (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
    .wr_y(wr_y), .wr_radius(wr_radius), .wr_valid(wr_valid),
    .req_valid(req_valid), .req_ready(readyO[0]), .check_x(check_x),
    .check_y(check_y), .shape(shape), .resp_valid(respO[0]), .hit(hitO[0]),
    .hit_idx(idxO[0]), .hit_count(cntO[0])
  );

  collision_scanner #(.N_OBJ(N), .XW(XW), .YW(YW), .EARLY_EXIT(1'b1)) uEarly (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
    .wr_y(wr_y), .wr_radius(wr_radius), .wr_valid(wr_valid),
    .req_valid(req_valid), .req_ready(readyO[1]), .check_x(check_x),
    .check_y(check_y), .shape(shape), .resp_valid(respO[1]), .hit(hitO[1]),
    .hit_idx(idxO[1]), .hit_count(cntO[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  acceptT = 0;
  int  lastResp [2];
  bit  mBusy [2];
  int  mResp [2];
  bit  mHit  [2];
  int  mIdx  [2];
  int  mCnt  [2];
  int  mX [N];
  int  mY [N];
  int  mR [N];
  bit  mV [N];

  task automatic checkOutput(input string name, input int e, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, e, cyc, act, exp);
    end
  endtask

  function automatic bit collides(input int k, input int cx, input int cy, input bit sh);
    int dx, dy;
    if (!mV[k]) return 1'b0;
    dx = cx - mX[k];
    dy = cy - mY[k];
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    if (sh) return mR[k] > dx + dy;
    return (mR[k] > dx) && (mR[k] > dy);
  endfunction

  // Model: the whole scan outcome and its response cycle are computed at accept.
  always @(posedge Clk) begin : model
    bit rp [2];
    int first;
    int total;
    if (Reset) begin
      cyc++;
      for (int k = 0; k < N; k++) mV[k] = 1'b0;
      for (int e = 0; e < 2; e++) begin
        mBusy[e] = 1'b0; mResp[e] = -1; mHit[e] = 1'b0; mIdx[e] = 0; mCnt[e] = 0;
      end
    end else begin
      for (int e = 0; e < 2; e++) rp[e] = !mBusy[e];
      if (wr_en) begin
        mX[wr_idx] = int'(wr_x);
        mY[wr_idx] = int'(wr_y);
        mR[wr_idx] = int'(wr_radius);
        mV[wr_idx] = wr_valid;
      end
      cyc++;
      for (int e = 0; e < 2; e++)
        if (mBusy[e] && cyc > mResp[e]) mBusy[e] = 1'b0;
      if (req_valid) begin
        first = -1;
        total = 0;
        for (int k = 0; k < N; k++)
          if (collides(k, int'(check_x), int'(check_y), shape)) begin
            total++;
            if (first < 0) first = k;
          end
        for (int e = 0; e < 2; e++)
          if (rp[e]) begin
            mBusy[e] = 1'b1;
            mHit[e]  = (first >= 0);
            mIdx[e]  = (first >= 0) ? first : 0;
            if (e == 1 && first >= 0) begin
              mCnt[e]  = 1;
              mResp[e] = cyc + first + 1;
            end else begin
              mCnt[e]  = total;
              mResp[e] = cyc + N;
            end
          end
      end
    end
  end

  always @(negedge Clk) begin : compare
    if (cyc > 0) begin
      for (int e = 0; e < 2; e++) begin
        if (respO[e] === 1'b1) lastResp[e] = cyc;
        checkOutput("req_ready", e, int'(readyO[e]), int'(!mBusy[e]));
        checkOutput("resp_valid", e, int'(respO[e]), int'(mBusy[e] && cyc == mResp[e]));
        if (!mBusy[e] || cyc == mResp[e]) begin
          checkOutput("hit", e, int'(hitO[e]), int'(mHit[e]));
          checkOutput("hit_idx", e, int'(idxO[e]), mIdx[e]);
          checkOutput("hit_count", e, int'(cntO[e]), mCnt[e]);
        end
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((mBusy[0] || mBusy[1]) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (mBusy[0] || mBusy[1]) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic writeSlot(input int idx, input int x, input int y, input int r, input bit v);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_x = XW'(x); wr_y = YW'(y);
    wr_radius = XW'(r); wr_valid = v;
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input bit sh);
    check_x = XW'(x); check_y = YW'(y); shape = sh;
    req_valid = 1'b1;
    acceptT = cyc;
    @(negedge Clk);
    req_valid = 1'b0;
    waitIdle();
  endtask

  task automatic expectResult(input string tag, input int e, input int h, input int idx,
                              input int cnt, input int lat);
    checkOutput({tag, "_hit"}, e, int'(hitO[e]), h);
    checkOutput({tag, "_idx"}, e, int'(idxO[e]), idx);
    checkOutput({tag, "_cnt"}, e, int'(cntO[e]), cnt);
    checkOutput({tag, "_lat"}, e, lastResp[e] - acceptT, lat);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    Reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_radius = '0;
    wr_valid = 1'b0; req_valid = 1'b0; check_x = '0; check_y = '0; shape = 1'b0;
    lastResp[0] = -100; lastResp[1] = -100;
    repeat (2) @(negedge Clk);
    req_valid = 1'b1;
    repeat (2) @(negedge Clk);
    req_valid = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);

    applyStimulus(5, 5, 1'b0);
    for (int e = 0; e < 2; e++) expectResult("empty", e, 0, 0, 0, N + 1);

    writeSlot(3, 100, 100, 10, 1'b1);
    applyStimulus(109, 91, 1'b0);
    expectResult("sq_in", 0, 1, 3, 1, N + 1);
    expectResult("sq_in", 1, 1, 3, 1, 5);
    applyStimulus(110, 100, 1'b0);
    for (int e = 0; e < 2; e++) expectResult("sq_edge", e, 0, 0, 0, N + 1);
    applyStimulus(105, 104, 1'b1);
    expectResult("dia_in", 0, 1, 3, 1, N + 1);
    expectResult("dia_in", 1, 1, 3, 1, 5);
    applyStimulus(105, 105, 1'b1);
    for (int e = 0; e < 2; e++) expectResult("dia_edge", e, 0, 0, 0, N + 1);

    writeSlot(3, 0, 0, 0, 1'b0);
    writeSlot(1, 48, 50, 4, 1'b1);
    writeSlot(4, 50, 53, 5, 1'b1);
    writeSlot(6, 50, 50, 1, 1'b1);
    applyStimulus(50, 50, 1'b0);
    expectResult("multi", 0, 1, 1, 3, N + 1);
    expectResult("multi", 1, 1, 1, 1, 3);

    writeSlot(1, 0, 0, 0, 1'b0);
    writeSlot(4, 0, 0, 0, 1'b0);
    writeSlot(6, 0, 0, 0, 1'b0);
    writeSlot(0, 0, 0, 5, 1'b1);
    applyStimulus(XMAX, 0, 1'b0);
    for (int e = 0; e < 2; e++) expectResult("nowrap", e, 0, 0, 0, N + 1);
    writeSlot(7, XMAX, 0, 3, 1'b1);
    applyStimulus(XMAX - 2, 0, 1'b0);
    for (int e = 0; e < 2; e++) expectResult("xmax", e, 1, 7, 1, N + 1);

    // Abort a scan with reset: the early instance would otherwise respond on slot 2.
    writeSlot(2, 200, 200, 8, 1'b1);
    check_x = XW'(200); check_y = YW'(200); shape = 1'b0;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(200, 200, 1'b0);
    for (int e = 0; e < 2; e++) expectResult("post_rst", e, 0, 0, 0, N + 1);

    writeSlot(2, 200, 200, 8, 1'b1);
    check_x = XW'(201); check_y = YW'(199); shape = 1'b1;
    req_valid = 1'b1;
    repeat (30) @(negedge Clk);
    req_valid = 1'b0;
    waitIdle();

    for (int it = 0; it < 200; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        writeSlot(int'($urandom_range(0, N - 1)), int'($urandom_range(80, 120)),
                  int'($urandom_range(80, 120)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) @(negedge Clk);
      applyStimulus(int'($urandom_range(70, 130)), int'($urandom_range(70, 130)),
                    1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
